// File: rtl/m_dram_arbiter.sv
// Arbiter sharing one multi-cycle DRAM port (re/oe protocol, one request in flight)
// between the I-fill and D load/store paths. Round-robin arbitration when DRAM_ARB_RR_EN is defined.
module m_dram_arbiter #(
  parameter int P_TIMEOUT = 64,
  parameter int P_CNT_W   = 8
) (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic        w_ireq,
  input  logic [31:0] w_iaddr,
  input  logic        w_dreq,
  input  logic [31:0] w_daddr,
  input  logic        w_dwe,
  input  logic [31:0] w_dwd,
  output logic        r_igrant,
  output logic        r_dgrant,
  output logic        r_ivalid,
  output logic        r_dvalid,
  output logic [31:0] r_rdata,
  output logic        r_busy,
  output logic        r_err,
  output logic        r_mem_re,
  output logic        r_mem_we,
  output logic [31:0] r_mem_addr,
  output logic [31:0] r_mem_wd,
  input  logic        w_mem_oe,
  input  logic [31:0] w_mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [P_CNT_W-1:0] TO_LAST = P_CNT_W'(P_TIMEOUT - 1);

  state_t             state;
  logic               owner_d;
  logic [P_CNT_W-1:0] wdog;
  logic               issue;
  logic               pick_d;

  assign issue = (state == IDLE) && (w_ireq || w_dreq);

`ifdef DRAM_ARB_RR_EN
  // last_d: side that won the most recent grant (1 = D); reset value D hands the first tie to I
  logic last_d;

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      last_d <= 1'b1;
    end else if (issue) begin
      last_d <= pick_d;
    end
  end

  assign pick_d = w_dreq && (!w_ireq || !last_d);
`else
  assign pick_d = w_dreq;
`endif

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      wdog       <= '0;
      r_igrant   <= 1'b0;
      r_dgrant   <= 1'b0;
      r_ivalid   <= 1'b0;
      r_dvalid   <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
    end else begin
      r_igrant <= 1'b0;
      r_dgrant <= 1'b0;
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      r_mem_re <= 1'b0;
      case (state)
        IDLE: begin
          r_busy <= 1'b0;
          if (issue) begin
            owner_d    <= pick_d;
            r_mem_re   <= 1'b1;
            r_mem_addr <= pick_d ? w_daddr : w_iaddr;
            r_mem_we   <= pick_d && w_dwe;
            r_mem_wd   <= pick_d ? w_dwd : 32'd0;
            r_igrant   <= !pick_d;
            r_dgrant   <= pick_d;
            state      <= WAIT;
          end
        end
        WAIT: begin
          r_busy <= 1'b1;
          wdog   <= wdog + P_CNT_W'(1);
          // A real completion takes precedence over a watchdog expiry in the same cycle
          if (w_mem_oe) begin
            r_rdata  <= r_mem_we ? 32'd0 : w_mem_rdata;
            r_ivalid <= !owner_d;
            r_dvalid <= owner_d;
            state    <= DONE;
          end else if (wdog == TO_LAST) begin
            r_rdata  <= 32'd0;
            r_ivalid <= !owner_d;
            r_dvalid <= owner_d;
            r_err    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          wdog   <= '0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Bench for m_dram_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (request queues, arbitration rule, latency arithmetic).
`timescale 1ns/1ps
module tb_m_dram_arbiter;

  localparam int TO   = 8;
  localparam int SI   = 0;
  localparam int SD   = 1;
  localparam int NONE = 2;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    int          lat;   // 0: DRAM never answers
  } req_t;

  logic        w_clock = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_ireq = 1'b0, w_dreq = 1'b0, w_dwe = 1'b0, w_mem_oe = 1'b0;
  logic [31:0] w_iaddr = '0, w_daddr = '0, w_dwd = '0, w_mem_rdata = '0;
  logic        r_igrant, r_dgrant, r_ivalid, r_dvalid, r_busy, r_err;
  logic        r_mem_re, r_mem_we;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wd;

  m_dram_arbiter #(.P_TIMEOUT(TO), .P_CNT_W(8)) dut (
    .w_clock(w_clock), .w_rst_n(w_rst_n),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_dreq(w_dreq), .w_daddr(w_daddr), .w_dwe(w_dwe), .w_dwd(w_dwd),
    .r_igrant(r_igrant), .r_dgrant(r_dgrant), .r_ivalid(r_ivalid), .r_dvalid(r_dvalid),
    .r_rdata(r_rdata), .r_busy(r_busy), .r_err(r_err),
    .r_mem_re(r_mem_re), .r_mem_we(r_mem_we), .r_mem_addr(r_mem_addr), .r_mem_wd(r_mem_wd),
    .w_mem_oe(w_mem_oe), .w_mem_rdata(w_mem_rdata)
  );

  always #5 w_clock = ~w_clock;

  int          checks = 0, errors = 0, cyc = 0;
  req_t        iq[$], dq[$], cur;
  int          inflight = NONE, last_win = SD, exp_g = -1, free_cyc = 0, g_cyc = 0, v_cyc = 0;
  logic [31:0] exp_rd = '0;
  bit          to_m = 0, err_m = 0;
  bit          pend = 0, stray = 0;
  int          dcnt = 0, cur_lat = 0;
  logic [31:0] dval = '0;

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return a ^ 32'h0000_0053;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".igrant"}, 32'(r_igrant), 32'd0);
    chk({tag, ".dgrant"}, 32'(r_dgrant), 32'd0);
    chk({tag, ".ivalid"}, 32'(r_ivalid), 32'd0);
    chk({tag, ".dvalid"}, 32'(r_dvalid), 32'd0);
    chk({tag, ".rdata"}, r_rdata, 32'd0);
    chk({tag, ".busy"}, 32'(r_busy), 32'd0);
    chk({tag, ".err"}, 32'(r_err), 32'd0);
    chk({tag, ".mem_re"}, 32'(r_mem_re), 32'd0);
    chk({tag, ".mem_we"}, 32'(r_mem_we), 32'd0);
    chk({tag, ".mem_addr"}, r_mem_addr, 32'd0);
    chk({tag, ".mem_wd"}, r_mem_wd, 32'd0);
  endtask

  // Winner among the sides with a pending request
  function automatic int pick();
    if (iq.size() > 0 && dq.size() > 0) begin
`ifdef DRAM_ARB_RR_EN
      return (last_win == SD) ? SI : SD;
`else
      return SD;
`endif
    end
    return (dq.size() > 0) ? SD : SI;
  endfunction

  task automatic drive();
    w_ireq = (iq.size() > 0);
    w_dreq = (dq.size() > 0);
    if (iq.size() > 0) w_iaddr = iq[0].addr;
    if (dq.size() > 0) begin
      w_daddr = dq[0].addr;
      w_dwe   = dq[0].we;
      w_dwd   = dq[0].wd;
    end
  endtask

  task automatic push(int side, logic [31:0] a, logic we, logic [31:0] wd, int lat);
    req_t r;
    r.addr = a;
    r.we   = (side == SD) ? we : 1'b0;
    r.wd   = wd;
    r.lat  = lat;
    if (inflight == NONE && exp_g < 0) exp_g = (free_cyc > cyc + 1) ? free_cyc : cyc + 1;
    if (side == SD) dq.push_back(r);
    else iq.push_back(r);
    drive();
  endtask

  // DRAM: answers r_mem_re after cur_lat cycles; writes return junk data on purpose
  task automatic dram_tick();
    w_mem_oe = 1'b0;
    if (stray) begin
      w_mem_oe    = 1'b1;
      w_mem_rdata = $urandom;
      stray       = 0;
    end
    if (pend) begin
      dcnt--;
      if (dcnt == 0) begin
        w_mem_oe    = 1'b1;
        w_mem_rdata = dval;
        pend        = 0;
      end
    end
    if (r_mem_re === 1'b1 && cur_lat != 0) begin
      pend = 1;
      dcnt = cur_lat;
      dval = r_mem_we ? 32'hFFFF_FFFF : rd_fn(r_mem_addr);
    end
  endtask

  task automatic step();
    int w;
    @(negedge w_clock);
    cyc++;
    if (cyc == exp_g) begin
      w = pick();
      if (w == SD) cur = dq.pop_front();
      else cur = iq.pop_front();
      chk("grant", 32'({r_dgrant, r_igrant}), (w == SD) ? 32'd2 : 32'd1);
      chk("mem_re", 32'(r_mem_re), 32'd1);
      chk("mem_addr", r_mem_addr, cur.addr);
      chk("mem_we", 32'(r_mem_we), 32'(cur.we));
      if (w == SD) chk("mem_wd", r_mem_wd, cur.wd);
      inflight = w;
      g_cyc    = cyc;
      last_win = w;
      exp_g    = -1;
      cur_lat  = cur.lat;
      if (cur.lat >= 1 && cur.lat <= TO - 1) begin
        v_cyc  = cyc + cur.lat + 1;
        exp_rd = cur.we ? 32'd0 : rd_fn(cur.addr);
        to_m   = 0;
      end else begin
        v_cyc  = cyc + TO;
        exp_rd = 32'd0;
        to_m   = 1;
      end
    end else begin
      chk("no_grant", 32'({r_dgrant, r_igrant}), 32'd0);
      chk("no_mem_re", 32'(r_mem_re), 32'd0);
    end
    chk("busy", 32'(r_busy), 32'(inflight != NONE && cyc > g_cyc));
    if (inflight != NONE && cyc == v_cyc) begin
      chk("valid", 32'({r_dvalid, r_ivalid}), (inflight == SD) ? 32'd2 : 32'd1);
      chk("rdata", r_rdata, exp_rd);
      chk("addr_held", r_mem_addr, cur.addr);
      if (to_m) err_m = 1;
      inflight = NONE;
      free_cyc = cyc + 2;
      if (iq.size() > 0 || dq.size() > 0) exp_g = cyc + 2;
    end else begin
      chk("no_valid", 32'({r_dvalid, r_ivalid}), 32'd0);
    end
    chk("err", 32'(r_err), 32'(err_m));
    drive();
    dram_tick();
  endtask

  task automatic run(int budget);
    int n = 0;
    while ((inflight != NONE || iq.size() > 0 || dq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL run_budget observed=%0d expected_below=%0d", n, budget);
    end
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int ni, nd;
    // Reset state
    repeat (3) begin @(negedge w_clock); cyc++; end
    check_zero("reset");
    w_rst_n  = 1'b1;
    free_cyc = cyc + 1;
    step();

    // Single I read, latency 3, data 0x13
    push(SI, 32'h40, 1'b0, 32'd0, 3);
    run(40);

    // Simultaneous D write and I read: D first, I two cycles after D's valid
    push(SD, 32'h80, 1'b1, 32'h0000_DEAD, 4);
    push(SI, 32'h100, 1'b0, 32'd0, 2);
    run(60);

    // Both sides held for four transactions each
    for (int k = 0; k < 4; k++) begin
      push(SD, 32'h1000 + 32'(k * 4), 1'(k & 1), $urandom, 2);
      push(SI, 32'h2000 + 32'(k * 4), 1'b0, 32'd0, 1);
    end
    run(200);

    // oe in the same cycle the watchdog expires: data returned, no error
    push(SD, 32'h200, 1'b0, 32'd0, TO - 1);
    run(40);

    // DRAM silent: timeout, sticky error, stray oe in IDLE ignored, next request normal
    push(SI, 32'h300, 1'b0, 32'd0, 0);
    run(40);
    stray = 1;
    step();
    step();
    push(SD, 32'h304, 1'b1, 32'h0000_1234, 2);
    run(40);
    push(SI, 32'h308, 1'b0, 32'd0, TO);
    run(40);

    // Reset one cycle into WAIT; late oe afterwards must be ignored
    push(SI, 32'h400, 1'b0, 32'd0, 5);
    n = 0;
    while (inflight == NONE && n < 20) begin step(); n++; end
    step();
    w_rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    iq.delete();
    dq.delete();
    inflight = NONE;
    err_m    = 0;
    last_win = SD;
    exp_g    = -1;
    drive();
    repeat (2) begin @(negedge w_clock); cyc++; dram_tick(); end
    check_zero("rst_hold");
    w_rst_n  = 1'b1;
    free_cyc = cyc + 1;
    repeat (6) step();
    push(SI, 32'h404, 1'b0, 32'd0, 2);
    run(40);

    // Random traffic
    for (int r = 0; r < 10; r++) begin
      ni = int'($urandom_range(0, 3));
      nd = int'($urandom_range(0, 3));
      if (ni + nd == 0) ni = 1;
      if ($urandom_range(0, 3) == 0) begin
        stray = 1;
        step();
      end
      for (int i = 0; i < ni; i++)
        push(SI, $urandom & 32'hFFFF_FFFC, 1'b0, 32'd0, int'($urandom_range(0, 9)));
      for (int d = 0; d < nd; d++)
        push(SD, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 9)));
      run(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
